fft_frame_sched: RTL



---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_hs_counter.sv | 27 ++
 rtl/fft_frame_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT frame scheduler.
// State encoding, size defaults and core select encodings.
package fft_pkg;

  localparam int DEF_N_PTS      = 8;
  localparam int DEF_CORE_TICKS = 8;
  localparam int DEF_TICK_W     = 3;
  localparam int DEF_CNT_W      = 4;

  localparam logic SEL_SP  = 1'b0;
  localparam logic SEL_REG = 1'b1;
  localparam logic SEL_PS  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COMP  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/fft_hs_counter.sv
// Handshake-qualified up-counter with terminal-count flag.
// Wraps to zero on the handshake taken at the terminal count.
module fft_hs_counter #(
  parameter int W    = 4,
  parameter int TERM = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = (r_cnt == W'(TERM - 1));

  // count handshakes, self-clear after the last one
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the 8-point FFT: load, compute, flush, drain.
// Define FFT_OVERLAP_EN to overlap next-frame loading with DRAIN.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int N_PTS      = DEF_N_PTS,
  parameter int CORE_TICKS = DEF_CORE_TICKS,
  parameter int TICK_W     = DEF_TICK_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              s_p_shift,
  output logic              mux_flag,
  output logic              demux_flag,
  output logic [TICK_W-1:0] rotation,
  output logic              p_s_load,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              p_s_shift,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [TICK_W-1:0] HALF =
    TICK_W'(CORE_TICKS / 2);
  localparam logic [TICK_W-1:0] LAST_TICK =
    TICK_W'(CORE_TICKS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] r_rot;
  logic              r_mux;
  logic              r_demux;
  logic              w_in_ready;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_ld_tc;
  logic              w_dr_tc;
  logic              w_ld_last;
  logic              w_dr_last;
  logic              w_idle;

`ifdef FFT_OVERLAP_EN
  logic r_ld_done;
  logic r_ld_part;
`endif

  assign w_idle    = (r_state == S_IDLE);
  assign w_in_hs   = in_valid & w_in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign w_ld_last = w_in_hs & w_ld_tc;
  assign w_dr_last = w_out_hs & w_dr_tc;

  fft_hs_counter #(
    .W    (CNT_W),
    .TERM (N_PTS)
  ) u_load_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_idle),
    .i_inc (w_in_hs),
    .o_tc  (w_ld_tc)
  );

  fft_hs_counter #(
    .W    (CNT_W),
    .TERM (N_PTS)
  ) u_drain_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_idle),
    .i_inc (w_out_hs),
    .o_tc  (w_dr_tc)
  );

  // input acceptance window
  always_comb begin
    w_in_ready = (r_state == S_LOAD);
`ifdef FFT_OVERLAP_EN
    if (r_state == S_DRAIN && en && !r_ld_done) begin
      w_in_ready = 1'b1;
    end
`endif
  end

  // next-state decision
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_ld_last) w_state_nxt = S_COMP;
      end
      S_COMP: begin
        if (r_tick == LAST_TICK) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_dr_last) begin
`ifdef FFT_OVERLAP_EN
          if (r_ld_done || w_ld_last) begin
            w_state_nxt = S_COMP;
          end else if (en || r_ld_part ||
                       (w_in_hs && !w_ld_tc)) begin
            w_state_nxt = S_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
`else
          w_state_nxt = en ? S_LOAD : S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // core tick runs only inside COMPUTE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick <= '0;
    end else if (r_state == S_COMP &&
                 r_tick != LAST_TICK) begin
      r_tick <= r_tick + 1'b1;
    end else begin
      r_tick <= '0;
    end
  end

  // core controls lag the tick by one cycle
  always_ff @(posedge clk) begin
    if (rst || r_state != S_COMP) begin
      r_rot   <= '0;
      r_mux   <= SEL_SP;
      r_demux <= SEL_PS;
    end else begin
      r_rot   <= r_tick;
      r_mux   <= (r_tick >= HALF) ? SEL_REG : SEL_SP;
      r_demux <= (r_tick <  HALF) ? SEL_REG : SEL_PS;
    end
  end

`ifdef FFT_OVERLAP_EN
  // track next-frame loading progress during DRAIN
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_DRAIN && w_dr_last)) begin
      r_ld_done <= 1'b0;
      r_ld_part <= 1'b0;
    end else if (r_state == S_DRAIN && w_in_hs) begin
      r_ld_done <= r_ld_done | w_ld_tc;
      r_ld_part <= !w_ld_tc;
    end
  end
`endif

  assign in_ready   = w_in_ready;
  assign s_p_shift  = w_in_hs;
  assign mux_flag   = r_mux;
  assign demux_flag = r_demux;
  assign rotation   = r_rot;
  assign p_s_load   = (r_state == S_FLUSH);
  assign out_valid  = (r_state == S_DRAIN);
  assign p_s_shift  = w_out_hs;
  assign busy       = !w_idle;
  assign frame_done = w_dr_last;

endmodule
